// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: holds the MEM stage while a load or store is in flight.
// Optional access timeout with a sticky bus_err is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        memop;
  logic        tmo_hit;

  assign memop = MemWriteM | (ResultSrcM == 2'b01);

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (memop) begin
          state_d     = ACCESS;
          mem_addr_d  = ALUResultM;
          mem_wdata_d = WriteDataM;
          mem_we_d    = MemWriteM;
        end
      end
      ACCESS: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (mem_ack) begin
          state_d = DONE;
          if (!mem_we_q) rdata_d = mem_rdata;
        end else if (tmo_hit) begin
          state_d = DONE;
          rdata_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d == ACCESS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       bus_err_q, bus_err_d;

  assign tmo_hit = (tmo_cnt_q == 8'(TIMEOUT - 1));

  // Counter sits at zero outside ACCESS, so every access starts a fresh count.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    bus_err_d = bus_err_q;
    if (state_q != ACCESS) begin
      tmo_cnt_d = '0;
    end else if (!mem_ack) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
      if (tmo_hit) bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ReadDataM = rdata_q;
  assign StallM    = ((state_q == IDLE) & memop) | (state_q == ACCESS);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a memory responder plus a transaction-level
// model predicting stall length, request count, captured data and the error flag.
module tb_dmem_access_ctrl;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, StallM, bus_err;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .StallM(StallM), .ReadDataM(ReadDataM), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, mem_req}, 32'd0);
    check({tag, "_we"},    {31'd0, mem_we},  32'd0);
    check({tag, "_addr"},  mem_addr,  32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata"}, ReadDataM, 32'd0);
    check({tag, "_err"},   {31'd0, bus_err}, 32'd0);
  endtask

  // kind: 0 non-memory, 1 load, 2 store, 3 store with load marker also set.
  // delay: ACCESS cycles without ack before the responder acks.
  // Called just after a rising edge with the controller idle.
  task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay, input bit spur);
    bit memop, we, timed_out, done;
    int stalls, reqs, acc, exp_access, r;
    memop = (kind != 0);
    we    = (kind >= 2);
    timed_out = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    timed_out = memop && (delay >= TMO);
`endif
    exp_access = timed_out ? TMO : delay + 1;
    stalls = 0; reqs = 0; acc = 0; done = 1'b0;

    MemWriteM  = we;
    ALUResultM = addr;
    WriteDataM = wdata;
    if (kind == 1 || kind == 3) ResultSrcM = 2'b01;
    else begin
      r = int'($urandom_range(0, 2));
      ResultSrcM = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
    end

    if (memop) begin
      if (timed_out) exp_rdata = '0;
      else if (!we)  exp_rdata = rdata;
    end
    exp_err = exp_err | timed_out;

    for (int c = 0; c < 300 && !done; c++) begin
      if (mem_req) begin
        acc++;
        mem_ack   = (acc > delay);
        mem_rdata = (acc > delay) ? rdata : $urandom;
      end else begin
        mem_ack   = spur ? 1'b1 : 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(negedge clk);
      if (StallM) stalls++;
      if (mem_req) begin
        reqs++;
        check("access_addr", mem_addr, addr);
        check("access_we", {31'd0, mem_we}, {31'd0, we});
        if (we) check("access_wdata", mem_wdata, wdata);
      end
      if (!StallM) begin
        done = 1'b1;
        check("done_req", {31'd0, mem_req}, 32'd0);
        check("done_rdata", ReadDataM, exp_rdata);
        check("done_err", {31'd0, bus_err}, {31'd0, exp_err});
        if (memop) begin
          check("done_addr", mem_addr, addr);
          check("done_we", {31'd0, mem_we}, {31'd0, we});
          if (we) check("done_wdata", mem_wdata, wdata);
        end
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    check("op_finished", {31'd0, done}, 32'd1);
    check("stall_cycles", stalls, memop ? exp_access + 1 : 0);
    check("req_cycles", reqs, memop ? exp_access : 0);
    $display("op kind=%0d addr=%h delay=%0d stalls=%0d reqs=%0d rdata=%h err=%0b",
             kind, addr, delay, stalls, reqs, ReadDataM, bus_err);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    check("reset_stall", {31'd0, StallM}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Directed: single-cycle load, slow store, two back-to-back loads.
    run_op(1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    check("load_we", {31'd0, mem_we}, 32'd0);
    run_op(2, 32'h0000_0204, 32'h1234_5678, 32'hCAFE_0000, 2, 1'b0);
    run_op(1, 32'h0000_0010, 32'h0, 32'h1111_2222, 0, 1'b0);
    run_op(1, 32'h0000_0014, 32'h0, 32'h3333_4444, 0, 1'b0);
    // Spurious ack with no memory op, then both flags set (store wins).
    run_op(0, 32'h0000_0400, 32'h0, 32'h5555_5555, 0, 1'b1);
    run_op(3, 32'h0000_0408, 32'hA5A5_5A5A, 32'h6666_6666, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 6)), 1'b0);
    end

`ifdef DMEM_TIMEOUT_EN
    run_op(1, 32'h0000_0800, 32'h0, 32'h7777_7777, 1000, 1'b0);
    check("tmo_err", {31'd0, bus_err}, 32'd1);
    run_op(1, 32'h0000_0804, 32'h0, 32'h8888_8888, TMO - 1, 1'b0);
    run_op(2, 32'h0000_0808, 32'h9999_0000, 32'h0, 1, 1'b0);
`endif

    // Reset in the second ACCESS cycle, then a late ack that must be ignored.
    MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h0000_0300; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_pre_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    ResultSrcM = 2'b00;
    #1;
    check("rst_mid_stall", {31'd0, StallM}, 32'd0);
    exp_rdata = '0;
    exp_err   = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_late_ack");
    check("rst_late_stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    run_op(1, 32'h0000_0C00, 32'h0, 32'h0BAD_F00D, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum ACCESS cycles without mem_ack before abort; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 MemWriteM  input  1  instruction in MEM stage is a store.
REQ-005 ResultSrcM  input  2  2'b01 marks a load in MEM stage.
REQ-006 ALUResultM  input  32  byte address of the access.
REQ-007 WriteDataM  input  32  store data.
REQ-008 mem_ack  input  1  data memory single-cycle completion pulse.
REQ-009 mem_rdata  input  32  load data, valid only when mem_ack=1.
REQ-010 mem_req  output  1  registered request to data memory.
REQ-011 mem_we  output  1  registered write enable, 1 for store.
REQ-012 mem_addr  output  32  registered address.
REQ-013 mem_wdata  output  32  registered store data.
REQ-014 StallM  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers; combinational.
REQ-015 ReadDataM  output  32  captured load data, valid in DONE.
REQ-016 bus_err  output  1  sticky timeout flag.

Function
REQ-017 memop = MemWriteM | (ResultSrcM == 2'b01); MemWriteM takes priority if both are set (mem_we=1).
REQ-018 FSM states IDLE, ACCESS, DONE; 2-bit encoding.
REQ-019 IDLE: memop=1 -> ACCESS, latching mem_addr/mem_wdata/mem_we from inputs at that edge; memop=0 -> stay.
REQ-020 ACCESS: mem_req=1 on every cycle in ACCESS and 0 in all other states.
REQ-021 ACCESS: mem_ack=1 -> DONE; for loads, mem_rdata is captured into ReadDataM at that edge; for stores, ReadDataM is held.
REQ-022 DONE -> IDLE unconditionally after one cycle; the MEM instruction advances at the end of DONE.
REQ-023 StallM = (IDLE & memop) | ACCESS; StallM=0 in DONE.
REQ-024 Minimum access latency: 2 stall cycles (ack in first ACCESS cycle); each additional ACCESS cycle adds one stall cycle.
REQ-025 Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE; no op is issued twice.
REQ-026 mem_ack in IDLE or DONE is ignored; no state or data change.
REQ-027 mem_addr/mem_wdata/mem_we hold stable from ACCESS entry until leaving DONE.
REQ-028 Non-memory instructions pass with StallM=0 and no FSM change.

Reset
REQ-029 Asynchronous reset forces IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, bus_err=0, timeout counter=0, immediately on assertion.
REQ-030 Reset during ACCESS drops mem_req in the same cycle; any later mem_ack is ignored.
REQ-031 After deassertion, the first rising edge evaluates from IDLE.

Configuration
REQ-032 Macro DMEM_TIMEOUT_EN defined: an 8-bit counter clears on ACCESS entry and increments each ACCESS cycle without ack.
REQ-033 With DMEM_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 without ack: go to DONE, set ReadDataM=0, set bus_err=1 (sticky until reset).
REQ-034 With DMEM_TIMEOUT_EN defined, ack on the same cycle the counter reaches TIMEOUT-1 wins: normal completion, bus_err unchanged.
REQ-035 DMEM_TIMEOUT_EN undefined: ACCESS waits indefinitely, no counter logic exists, bus_err tied to 0.

Verification
REQ-036 Load addr 0x100, mem_ack one cycle after mem_req rises, mem_rdata=0xDEADBEEF -> StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE, mem_we=0.
REQ-037 Store addr 0x204, data 0x12345678, ack after 3 ACCESS cycles -> mem_we=1, mem_wdata=0x12345678 stable throughout, StallM high 4 cycles.
REQ-038 Two consecutive loads, ack immediate each -> exactly two mem_req pulses, each 1 cycle wide, StallM pattern 1,1,0,1,1,0.
REQ-039 DMEM_TIMEOUT_EN defined, TIMEOUT=16, no ack -> abort after 16 ACCESS cycles, bus_err=1, ReadDataM=0; next op then proceeds normally with bus_err still 1.
REQ-040 Reset asserted in 2nd ACCESS cycle, then mem_ack pulse -> mem_req=0 at once, state IDLE, ack ignored, all outputs at reset values.
REQ-041 Spurious mem_ack with memop=0 -> no state change, StallM=0, ReadDataM unchanged.
